// File: rtl/adder_final_pkg.sv
// Shared constants and types for the final carry-save-to-binary adder.
package adder_final_pkg;

    // Number of input columns, which is also the operand width.
    localparam int N_COL   = 14;
    // Width of one first-level lookahead group.
    localparam int GROUP_W = 4;

    typedef logic [N_COL-1:0]   operand_t;
    typedef logic [GROUP_W-1:0] group_t;

endpackage

// File: rtl/adder_final_cla4.sv
// 4-bit carry-lookahead block: local sum plus group generate/propagate for
// the second-level lookahead.
module adder_cla4
    import adder_final_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] gb;
    logic [GROUP_W-1:0] pb;
    logic [GROUP_W-1:0] c;

    // Bit generate/propagate, flattened in-group carries, and group terms.
    always_comb begin
        gb   = a & b;
        pb   = a ^ b;
        c[0] = cin;
        c[1] = gb[0] | (pb[0] & cin);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cin);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & cin);
        sum  = pb ^ c;
        g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
        p    = &pb;
    end

endmodule

// File: rtl/adder_final.sv
// Final adder: converts a 14-column carry-save pair into a binary sum using
// a two-level carry-lookahead tree, with a registered copy of the result.
module adder_final
    import adder_final_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       x0,
    input  logic [1:0]       x1,
    input  logic [1:0]       x2,
    input  logic [1:0]       x3,
    input  logic [1:0]       x4,
    input  logic [1:0]       x5,
    input  logic [1:0]       x6,
    input  logic [1:0]       x7,
    input  logic [1:0]       x8,
    input  logic [1:0]       x9,
    input  logic [1:0]       x10,
    input  logic [1:0]       x11,
    input  logic [1:0]       x12,
    input  logic [1:0]       x13,
    output logic [N_COL-1:0] out,
    output logic             cout,
    output logic [N_COL-1:0] out_q,
    output logic             cout_q
);

    operand_t a;
    operand_t b;

    group_t   s0, s1, s2, s3;
    logic     g0, g1, g2, g3;
    logic     p0, p1, p2, p3;
    logic     c4, c8, c12;

    // Column unpacking: x0 is the MSB column, bit 0 is operand A, bit 1 is B.
    always_comb begin
        a = {x0[0], x1[0], x2[0], x3[0], x4[0], x5[0], x6[0],
             x7[0], x8[0], x9[0], x10[0], x11[0], x12[0], x13[0]};
        b = {x0[1], x1[1], x2[1], x3[1], x4[1], x5[1], x6[1],
             x7[1], x8[1], x9[1], x10[1], x11[1], x12[1], x13[1]};
    end

    adder_cla4 u_grp0 (
        .a   (a[3:0]),
        .b   (b[3:0]),
        .cin (1'b0),
        .sum (s0),
        .g   (g0),
        .p   (p0)
    );

    adder_cla4 u_grp1 (
        .a   (a[7:4]),
        .b   (b[7:4]),
        .cin (c4),
        .sum (s1),
        .g   (g1),
        .p   (p1)
    );

    adder_cla4 u_grp2 (
        .a   (a[11:8]),
        .b   (b[11:8]),
        .cin (c8),
        .sum (s2),
        .g   (g2),
        .p   (p2)
    );

    // Top group only carries bits 13:12; its upper inputs are tied low.
    adder_cla4 u_grp3 (
        .a   ({2'b00, a[13:12]}),
        .b   ({2'b00, b[13:12]}),
        .cin (c12),
        .sum (s3),
        .g   (g3),
        .p   (p3)
    );

    // Second-level lookahead: every group carry-in derived directly from
    // group generate/propagate, with no ripple between groups.
    always_comb begin
        c4  = g0;
        c8  = g1 | (p1 & g0);
        c12 = g2 | (p2 & g1) | (p2 & p1 & g0);
        out = {s3[1:0], s2, s1, s0};
        // With bits 3:2 of the top group tied low, the carry out of bit 13
        // lands on s3[2]. s3[3], g3 and p3 are all zero in that case, so
        // OR-ing them in leaves the result unchanged.
        cout = s3[2] | s3[3] | g3 | (p3 & c12);
    end

    // Output register: one-cycle copy of the sum, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out;
            cout_q <= cout;
        end
    end

endmodule

// File: tb/tb_adder_final.sv
// Directed and random checks of adder_final: combinational sum, registered
// copy, and asynchronous reset behaviour.
module tb_adder_final;

    logic        clk;
    logic        reset;
    logic [1:0]  xs [0:13];
    logic [13:0] out;
    logic        cout;
    logic [13:0] out_q;
    logic        cout_q;

    int n_assert;
    int n_fail;

    logic [13:0] ra;
    logic [13:0] rb;
    logic [14:0] exp_sum;

    adder_final dut (
        .clk    (clk),
        .reset  (reset),
        .x0     (xs[0]),
        .x1     (xs[1]),
        .x2     (xs[2]),
        .x3     (xs[3]),
        .x4     (xs[4]),
        .x5     (xs[5]),
        .x6     (xs[6]),
        .x7     (xs[7]),
        .x8     (xs[8]),
        .x9     (xs[9]),
        .x10    (xs[10]),
        .x11    (xs[11]),
        .x12    (xs[12]),
        .x13    (xs[13]),
        .out    (out),
        .cout   (cout),
        .out_q  (out_q),
        .cout_q (cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ab(input logic [13:0] a, input logic [13:0] b);
        for (int k = 0; k < 14; k++) begin
            xs[k] = {b[13-k], a[13-k]};
        end
    endtask

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_ab(14'h0000, 14'h0000);
        #1;
        chk("reset_out_q",  {1'b0, out_q}, 15'h0000);
        chk("reset_cout_q", {14'h0, cout_q}, 15'h0000);

        // Reset held across clock edges: registers stay clear, out tracks.
        set_ab(14'h0123, 14'h0456);
        @(posedge clk); #1;
        chk("rst_hold_out_q", {cout_q, out_q}, 15'h0000);
        chk("rst_hold_out",   {cout, out},     15'h0579);

        // All zero columns.
        @(negedge clk);
        set_ab(14'h0000, 14'h0000);
        reset = 1'b0;
        #1;
        chk("zero_out", {cout, out}, 15'h0000);
        @(posedge clk); #1;
        chk("zero_out_q", {cout_q, out_q}, 15'h0000);

        // Full carry chain: 3FFF + 1.
        @(negedge clk);
        for (int k = 0; k < 13; k++) xs[k] = 2'b01;
        xs[13] = 2'b11;
        #1;
        chk("chain_out", {cout, out}, 15'h4000);
        @(posedge clk); #1;
        chk("chain_out_q", {cout_q, out_q}, 15'h4000);

        // Alternating bits, no carries.
        @(negedge clk);
        set_ab(14'h1555, 14'h2AAA);
        #1;
        chk("alt_out", {cout, out}, 15'h3FFF);

        // MSB-only overflow.
        set_ab(14'h2000, 14'h2000);
        #1;
        chk("msb_out", {cout, out}, 15'h4000);

        // Maximum operands.
        set_ab(14'h3FFF, 14'h3FFF);
        #1;
        chk("max_out", {cout, out}, 15'h7FFE);

        // Input change without a clock edge leaves registers untouched.
        @(posedge clk); #1;
        chk("max_out_q", {cout_q, out_q}, 15'h7FFE);
        set_ab(14'h0010, 14'h0020);
        #1;
        chk("noedge_out",   {cout, out},     15'h0030);
        chk("noedge_out_q", {cout_q, out_q}, 15'h7FFE);

        // Sweep of the combinational sum.
        for (int i = 0; i < 32768; i++) begin
            ra = i[13:0];
            rb = 14'(i + 1);
            set_ab(ra, rb);
            exp_sum = {1'b0, ra} + {1'b0, rb};
            #1;
            chk("sweep", {cout, out}, exp_sum);
        end

        // Asynchronous reset between clock edges.
        @(negedge clk);
        set_ab(14'h1234, 14'h0000);
        @(posedge clk); #1;
        chk("pre_rst_out_q", {cout_q, out_q}, 15'h1234);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_q", {cout_q, out_q}, 15'h0000);
        set_ab(14'h3000, 14'h1001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_hold", {cout_q, out_q}, 15'h0000);
        @(posedge clk); #1;
        chk("post_rst_load", {cout_q, out_q}, 15'h4001);

        // Random traffic with one-cycle registered latency.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = 14'($urandom);
            rb = 14'($urandom);
            set_ab(ra, rb);
            exp_sum = {1'b0, ra} + {1'b0, rb};
            @(posedge clk); #1;
            chk("rand_q", {cout_q, out_q}, exp_sum);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
